// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and constants for the memory access sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Read target select (is_fetch)
  localparam logic TGT_MDR = 1'b0;
  localparam logic TGT_IR  = 1'b1;

  // Address source select (iord)
  localparam logic IORD_PC  = 1'b0;
  localparam logic IORD_ALU = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request, memory and register-file signals of the access sequencer.
// Latency: n/a (wires only).
// Backpressure: none; req is sampled by the sequencer only while it is idle.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req;
  logic              we;
  logic              is_fetch;
  logic              iord;
  logic [ADDR_W-1:0] pc_addr;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] ir_out;
  logic [DATA_W-1:0] mdr_out;
  logic              fault;

  // Control unit plus memory side
  modport master (
    output req, we, is_fetch, iord, pc_addr, alu_addr, wdata, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, busy, done, ir_out, mdr_out, fault
  );

  // Sequencer side
  modport slave (
    input  req, we, is_fetch, iord, pc_addr, alu_addr, wdata, mem_rdata,
    output mem_addr, mem_wdata, mem_we, busy, done, ir_out, mdr_out, fault
  );

endinterface

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: loadable down-counter with zero flag, paces memory occupancy.
// Latency: load/decrement take effect on the next rising edge; zero flag is combinational.
// Backpressure: none; decrement saturates at zero.
module mem_lat_counter #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load takes priority over decrement; holding at zero keeps the flag stable
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multicycle-CPU memory sequencer (IorD mux, held bus, IR/MDR capture).
// Latency: req in cycle N -> ACCESS N+1..N+LAT, done pulse and captured data at N+LAT+1.
// Backpressure: req only sampled in IDLE; requester holds/re-asserts it until accepted.
// Optional MEM_ALIGN_CHECK_EN: misaligned requests skip the access and set sticky fault.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 3,
  parameter int WR_LAT = 2
) (
  input logic              clock,
  input logic              reset,
  mem_access_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(max_int(RD_LAT, WR_LAT)) + 1;
  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LAT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_tgt;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_mdr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_start;
  logic              w_capture;
  logic              w_in_access;
  logic              w_cnt_zero;
  logic [CNT_W-1:0]  w_cnt_load;

  assign w_sel_addr  = (bus.iord == IORD_ALU) ? bus.alu_addr : bus.pc_addr;
  assign w_in_access = (r_state == ACCESS);
  assign w_cnt_load  = bus.we ? WR_CNT : RD_CNT;

`ifdef MEM_ALIGN_CHECK_EN
  logic w_misaligned;
  logic r_fault;
  assign w_misaligned = (w_sel_addr[1:0] != 2'b00);
`endif

  // State register; async reset aborts any access in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus request-accept and read-capture strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          w_start     = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
          w_state_nxt = w_misaligned ? DONE : ACCESS;
`else
          w_state_nxt = ACCESS;
`endif
        end
      end
      ACCESS: begin
        if (w_cnt_zero) begin
          w_capture   = ~r_we;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  mem_lat_counter #(
    .W (CNT_W)
  ) u_lat_counter (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_start),
    .i_load_val (w_cnt_load),
    .i_dec      (w_in_access),
    .o_zero     (w_cnt_zero)
  );

  // Request latches: everything driven during ACCESS comes from here, not the inputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_tgt   <= TGT_MDR;
    end else if (w_start) begin
      r_addr  <= w_sel_addr;
      r_wdata <= bus.wdata;
      r_we    <= bus.we;
      r_tgt   <= bus.is_fetch;
    end
  end

  // IR/MDR capture on the last read cycle; each holds until its next capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ir  <= '0;
      r_mdr <= '0;
    end else if (w_capture) begin
      if (r_tgt == TGT_IR) begin
        r_ir <= bus.mem_rdata;
      end else begin
        r_mdr <= bus.mem_rdata;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Sticky misalignment flag, cleared only by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (w_start && w_misaligned) begin
      r_fault <= 1'b1;
    end
  end
  assign bus.fault = r_fault;
`else
  assign bus.fault = 1'b0;
`endif

  // Strobes decode from the state register only so reset drops them immediately
  assign bus.mem_we    = w_in_access && r_we;
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.ir_out    = r_ir;
  assign bus.mdr_out   = r_mdr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized and directed stimulus against a transaction-level model.
// Latency: model expects ACCESS for LAT cycles after req and done one cycle later.
// Backpressure: bench waits out each transaction before issuing the next request.
module tb_mem_access_ctrl;

  localparam int TB_RD_LAT = 3;
  localparam int TB_WR_LAT = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural state expected after each transaction
  logic [31:0] model_ir    = '0;
  logic [31:0] model_mdr   = '0;
  logic        model_fault = 1'b0;

  mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .RD_LAT (TB_RD_LAT),
    .WR_LAT (TB_WR_LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request from IDLE through the IDLE cycle after done
  task automatic do_access(input logic we_i, input logic fetch_i, input logic iord_i,
                           input logic [31:0] pc_i, input logic [31:0] alu_i,
                           input logic [31:0] wd_i, input logic [31:0] rd_i,
                           input bit hold_req, input bit scramble);
    logic [31:0] a;
    int lat;
    bit skip;
    a    = iord_i ? alu_i : pc_i;
    lat  = we_i ? TB_WR_LAT : TB_RD_LAT;
    skip = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    skip = (a[1:0] != 2'b00);
`endif
    if (skip) lat = 0;

    @(negedge clock);
    bus.req       = 1'b1;
    bus.we        = we_i;
    bus.is_fetch  = fetch_i;
    bus.iord      = iord_i;
    bus.pc_addr   = pc_i;
    bus.alu_addr  = alu_i;
    bus.wdata     = wd_i;
    bus.mem_rdata = $urandom;

    for (int c = 1; c <= lat + 2; c++) begin
      @(negedge clock);
      if (c <= lat) begin
        check_val("acc_busy", bus.busy, 1);
        check_val("acc_done", bus.done, 0);
        check_val("acc_addr", bus.mem_addr, a);
        check_val("acc_we", bus.mem_we, we_i);
        if (we_i) check_val("acc_wdata", bus.mem_wdata, wd_i);
      end else if (c == lat + 1) begin
        if (skip) model_fault = 1'b1;
        if (!skip && !we_i) begin
          if (fetch_i) model_ir = rd_i;
          else model_mdr = rd_i;
        end
        check_val("done_pulse", bus.done, 1);
        check_val("done_busy", bus.busy, 1);
        check_val("done_we", bus.mem_we, 0);
        check_val("ir_out", bus.ir_out, model_ir);
        check_val("mdr_out", bus.mdr_out, model_mdr);
        check_val("fault", bus.fault, model_fault);
      end else begin
        check_val("idle_done", bus.done, 0);
        check_val("idle_busy", bus.busy, 0);
      end
      // Drive the next cycle's inputs after sampling this one
      if ((c == 1 && !hold_req) || c == lat + 2) bus.req = 1'b0;
      if (scramble) begin
        bus.pc_addr  = $urandom;
        bus.alu_addr = $urandom;
        bus.wdata    = $urandom;
        bus.we       = 1'($urandom_range(0, 1));
        bus.iord     = 1'($urandom_range(0, 1));
        bus.is_fetch = 1'($urandom_range(0, 1));
      end
      bus.mem_rdata = (c == lat) ? rd_i : $urandom;
    end
  endtask

  task automatic reset_mid_store();
    @(negedge clock);
    bus.req      = 1'b1;
    bus.we       = 1'b1;
    bus.iord     = 1'b1;
    bus.alu_addr = 32'h0000_0100;
    bus.wdata    = 32'hCAFE_F00D;
    @(negedge clock);
    check_val("rst_pre_we", bus.mem_we, 1);
    bus.req = 1'b0;
    reset   = 1'b1;
    #1;
    model_ir    = '0;
    model_mdr   = '0;
    model_fault = 1'b0;
    check_val("rst_we", bus.mem_we, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.done, 0);
    check_val("rst_addr", bus.mem_addr, 0);
    check_val("rst_wdata", bus.mem_wdata, 0);
    check_val("rst_ir", bus.ir_out, model_ir);
    check_val("rst_mdr", bus.mdr_out, model_mdr);
    check_val("rst_fault", bus.fault, model_fault);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_val("rst_no_done", bus.done, 0);
      check_val("rst_idle", bus.busy, 0);
    end
  endtask

  initial begin
    logic [31:0] pc, alu;
    bus.req       = 1'b0;
    bus.we        = 1'b0;
    bus.is_fetch  = 1'b0;
    bus.iord      = 1'b0;
    bus.pc_addr   = '0;
    bus.alu_addr  = '0;
    bus.wdata     = '0;
    bus.mem_rdata = '0;

    #12;
    check_val("reset_addr", bus.mem_addr, 0);
    check_val("reset_wdata", bus.mem_wdata, 0);
    check_val("reset_we", bus.mem_we, 0);
    check_val("reset_busy", bus.busy, 0);
    check_val("reset_done", bus.done, 0);
    check_val("reset_ir", bus.ir_out, 0);
    check_val("reset_mdr", bus.mdr_out, 0);
    check_val("reset_fault", bus.fault, 0);
    @(negedge clock);
    reset = 1'b0;

    // Fetch, load, store
    do_access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 32'h8C22_0004, 1'b0, 1'b0);
    do_access(1'b0, 1'b0, 1'b1, 32'h10, 32'h44, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_access(1'b1, 1'b0, 1'b1, 32'h10, 32'h80, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    // Inputs scrambled during ACCESS, req held through DONE
    do_access(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'hA5A5_5A5A, 32'h0, 1'b1, 1'b1);
    do_access(1'b0, 1'b1, 1'b0, 32'h204, 32'h0, 32'h0, 32'h1357_9BDF, 1'b1, 1'b1);
    // Misaligned read, then an aligned load
    do_access(1'b0, 1'b0, 1'b1, 32'h0, 32'h42, 32'h0, 32'h0BAD_0BAD, 1'b0, 1'b0);
    do_access(1'b0, 1'b0, 1'b1, 32'h0, 32'h48, 32'h0, 32'h600D_600D, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      pc  = $urandom;
      alu = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        pc[1:0]  = 2'b00;
        alu[1:0] = 2'b00;
      end
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                pc, alu, $urandom, $urandom,
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    reset_mid_store();
    do_access(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 32'h0, 32'h2402_0001, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
